// File: rtl/branch_update_queue.sv
// branch_update_queue
// Buffers resolved conditional-branch records (PC, actual outcome, mispredict
// flag) between execute and the branch predictor's table-update port. The
// queue is first-word-fall-through and drains over a valid/ready handshake.
// Events arriving while the queue is full and not draining are dropped and
// tallied in a saturating counter.
//
// Optional build macro: BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN
//   Adds the mispred_count output, a saturating 32-bit tally of popped
//   records whose mispredict flag is set. It is cleared by rst only.
module branch_update_queue #(
    parameter int DEPTH          = 8,
    parameter int PC_WIDTH       = 32,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      data_valid,
    input  logic [6:0]                opcode,
    input  logic [2:0]                pcSource,
    input  logic [PC_WIDTH-1:0]       pc,
    input  logic                      pred_taken,
    input  logic                      flush,
    output logic                      upd_valid,
    input  logic                      upd_ready,
    output logic [PC_WIDTH-1:0]       upd_pc,
    output logic                      upd_taken,
    output logic                      upd_mispredict,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
`ifdef BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN
    ,
    output logic [31:0]               mispred_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [6:0] BRANCH_OPCODE = 7'b1100011;

    // Storage arrays carry no reset; their contents only matter once the
    // occupancy count says an entry is live.
    logic [PC_WIDTH-1:0]       r_pcMem    [DEPTH];
    logic                      r_takenMem [DEPTH];
    logic                      r_misMem   [DEPTH];

    logic [AW-1:0]             r_rdPtr;
    logic [AW-1:0]             r_wrPtr;
    logic [CW-1:0]             r_count;
    logic [DROP_CNT_WIDTH-1:0] r_dropCount;

    logic                      w_capture;
    logic                      w_taken;
    logic                      w_mispredict;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_pop;
    logic                      w_push;
    logic                      w_drop;

    // Decode the execute-stage instruction into a branch record.
    assign w_capture    = data_valid && (opcode == BRANCH_OPCODE);
    assign w_taken      = (pcSource == 3'd2);
    assign w_mispredict = w_taken ^ pred_taken;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // A flush cancels both the pop and the push of its cycle, so neither the
    // pointers nor the drop counter see them.
    assign w_pop  = !w_empty && upd_ready && !flush;
    assign w_push = w_capture && !flush && (!w_full || w_pop);
    assign w_drop = w_capture && !flush && w_full && !w_pop;

    assign upd_valid      = !w_empty;
    assign upd_pc         = w_empty ? '0   : r_pcMem[r_rdPtr];
    assign upd_taken      = w_empty ? 1'b0 : r_takenMem[r_rdPtr];
    assign upd_mispredict = w_empty ? 1'b0 : r_misMem[r_rdPtr];

    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;
    assign drop_count = r_dropCount;

    // Write the incoming record at the tail whenever it is accepted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pcMem[r_wrPtr]    <= pc;
            r_takenMem[r_wrPtr] <= w_taken;
            r_misMem[r_wrPtr]   <= w_mispredict;
        end
    end

    // Advance pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tally lost events, holding at all-ones; flush leaves the tally intact.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dropCount <= '0;
        end else if (w_drop && (r_dropCount != '1)) begin
            r_dropCount <= r_dropCount + 1'b1;
        end
    end

`ifdef BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN
    logic [31:0] r_mispredCount;

    assign mispred_count = r_mispredCount;

    // Count mispredicted records as the predictor consumes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispredCount <= '0;
        end else if (w_pop && upd_mispredict && (r_mispredCount != '1)) begin
            r_mispredCount <= r_mispredCount + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
// tb_branch_update_queue
// Directed bench for branch_update_queue. Stimulus pushes the record it
// expects onto a scoreboard queue; a monitor pops and compares whenever the
// DUT completes a handshake. Honours BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN.
module tb_branch_update_queue;

    localparam logic [6:0] BR_OP  = 7'b1100011;
    localparam logic [6:0] ALU_OP = 7'b0110011;

    typedef logic [33:0] rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dataValid;
    logic [6:0]  opcodeIn;
    logic [2:0]  pcSourceIn;
    logic [31:0] pcIn;
    logic        predTaken;
    logic        flushIn;
    logic        updValid;
    logic        updReady;
    logic [31:0] updPc;
    logic        updTaken;
    logic        updMispredict;
    logic [3:0]  countOut;
    logic        fullOut;
    logic        emptyOut;
    logic [15:0] dropCount;
`ifdef BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN
    logic [31:0] mispredCount;
`endif

    rec_t expQ[$];
    int   checksDone = 0;
    int   failCount  = 0;

    branch_update_queue #(
        .DEPTH(8),
        .PC_WIDTH(32),
        .DROP_CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_valid(dataValid),
        .opcode(opcodeIn),
        .pcSource(pcSourceIn),
        .pc(pcIn),
        .pred_taken(predTaken),
        .flush(flushIn),
        .upd_valid(updValid),
        .upd_ready(updReady),
        .upd_pc(updPc),
        .upd_taken(updTaken),
        .upd_mispredict(updMispredict),
        .count(countOut),
        .full(fullOut),
        .empty(emptyOut),
        .drop_count(dropCount)
`ifdef BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN
        ,
        .mispred_count(mispredCount)
`endif
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksDone++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of execute-stage input; queue the expected record if it
    // should be accepted. Returns one time unit after the clock edge.
    task automatic applyStimulus(input logic dv, input logic [6:0] op,
                                 input logic [2:0] src, input logic [31:0] pcVal,
                                 input logic pred, input logic fl,
                                 input logic expectStore);
        logic tk;
        dataValid  = dv;
        opcodeIn   = op;
        pcSourceIn = src;
        pcIn       = pcVal;
        predTaken  = pred;
        flushIn    = fl;
        if (expectStore) begin
            tk = (src == 3'd2);
            expQ.push_back({pcVal, tk, tk ^ pred});
        end
        @(posedge clk);
        #1;
        dataValid = 1'b0;
        flushIn   = 1'b0;
    endtask

    // Wait for the queue to drain, bounded by a cycle budget.
    task automatic waitEmpty(input int budget, input string name);
        int n;
        n = 0;
        while (!emptyOut && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(name, {31'd0, emptyOut}, 32'd1);
    endtask

    // Compare each handshake-completed head entry against the scoreboard.
    always @(negedge clk) begin
        rec_t e;
        if (!rst && updValid && updReady) begin
            checksDone++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpectedPop: got pc 0x%0h, expected no entry", updPc);
            end else begin
                e = expQ.pop_front();
                if ({updPc, updTaken, updMispredict} !== e) begin
                    failCount++;
                    $display("[TB] FAIL popRecord: got {0x%0h,%0b,%0b}, expected {0x%0h,%0b,%0b}",
                             updPc, updTaken, updMispredict, e[33:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        dataValid  = 1'b0;
        opcodeIn   = '0;
        pcSourceIn = '0;
        pcIn       = '0;
        predTaken  = 1'b0;
        flushIn    = 1'b0;
        updReady   = 1'b0;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstEmpty", {31'd0, emptyOut}, 32'd1);
        checkOutput("rstFull", {31'd0, fullOut}, 32'd0);
        checkOutput("rstCount", {28'd0, countOut}, 32'd0);
        checkOutput("rstValid", {31'd0, updValid}, 32'd0);
        checkOutput("rstPc", updPc, 32'd0);
        checkOutput("rstDrop", {16'd0, dropCount}, 32'd0);
`ifdef BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN
        checkOutput("rstMispred", mispredCount, 32'd0);
`endif
        rst = 1'b0;

        // Three captures held back, then drained in order.
        applyStimulus(1'b1, BR_OP, 3'd2, 32'h100, 1'b1, 1'b0, 1'b1);
        checkOutput("firstVisible", {31'd0, updValid}, 32'd1);
        applyStimulus(1'b1, BR_OP, 3'd0, 32'h104, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, BR_OP, 3'd2, 32'h108, 1'b0, 1'b0, 1'b1);
        checkOutput("count3", {28'd0, countOut}, 32'd3);
        checkOutput("head3Pc", updPc, 32'h100);
        checkOutput("head3Taken", {31'd0, updTaken}, 32'd1);
        checkOutput("head3Mis", {31'd0, updMispredict}, 32'd0);
        updReady = 1'b1;
        waitEmpty(10, "drain3");
        updReady = 1'b0;
        checkOutput("drain3Count", {28'd0, countOut}, 32'd0);
        checkOutput("drain3Sb", expQ.size(), 32'd0);

        // Fill to capacity, then two overflowing captures.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, BR_OP, (i % 2 == 0) ? 3'd2 : 3'd0,
                          32'h300 + 32'(4 * i), (i < 4), 1'b0, 1'b1);
        end
        applyStimulus(1'b1, BR_OP, 3'd2, 32'h380, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, BR_OP, 3'd2, 32'h384, 1'b0, 1'b0, 1'b0);
        checkOutput("fullFlag", {31'd0, fullOut}, 32'd1);
        checkOutput("fullCount", {28'd0, countOut}, 32'd8);
        checkOutput("dropTwo", {16'd0, dropCount}, 32'd2);
        checkOutput("stallHeadPc", updPc, 32'h300);

        // Full queue: capture and pop together.
        updReady = 1'b1;
        applyStimulus(1'b1, BR_OP, 3'd2, 32'h400, 1'b0, 1'b0, 1'b1);
        updReady = 1'b0;
        checkOutput("pushPopCount", {28'd0, countOut}, 32'd8);
        checkOutput("pushPopDrop", {16'd0, dropCount}, 32'd2);
        checkOutput("pushPopHead", updPc, 32'h304);
        updReady = 1'b1;
        waitEmpty(20, "drainFull");
        updReady = 1'b0;
        checkOutput("drainFullSb", expQ.size(), 32'd0);
`ifdef BRANCH_UPDATE_QUEUE_MISPRED_CNT_EN
        checkOutput("mispredCount", mispredCount, 32'd7);
`endif

        // Non-branch opcode and invalid branch are ignored.
        applyStimulus(1'b1, ALU_OP, 3'd2, 32'h500, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, BR_OP, 3'd2, 32'h504, 1'b0, 1'b0, 1'b0);
        checkOutput("ignoreCount", {28'd0, countOut}, 32'd0);
        checkOutput("ignoreValid", {31'd0, updValid}, 32'd0);

        // Four queued, then flush with a simultaneous capture.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, BR_OP, 3'd0, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b1);
        end
        checkOutput("count4", {28'd0, countOut}, 32'd4);
        expQ.delete();
        applyStimulus(1'b1, BR_OP, 3'd2, 32'h610, 1'b1, 1'b1, 1'b0);
        checkOutput("flushCount", {28'd0, countOut}, 32'd0);
        checkOutput("flushEmpty", {31'd0, emptyOut}, 32'd1);
        checkOutput("flushDrop", {16'd0, dropCount}, 32'd2);
        checkOutput("flushPcZero", updPc, 32'd0);
        applyStimulus(1'b1, BR_OP, 3'd2, 32'h200, 1'b1, 1'b0, 1'b1);
        checkOutput("postFlushValid", {31'd0, updValid}, 32'd1);
        checkOutput("postFlushPc", updPc, 32'h200);
        checkOutput("postFlushTaken", {31'd0, updTaken}, 32'd1);
        checkOutput("postFlushMis", {31'd0, updMispredict}, 32'd0);
        updReady = 1'b1;
        waitEmpty(10, "drainFlush");
        updReady = 1'b0;
        checkOutput("drainFlushSb", expQ.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checksDone, failCount);
        $finish;
    end

endmodule
